// File: rtl/store_buffer.sv
// In-order store FIFO between the MEM stage and a single-port byte-addressed data memory,
// with load-overlap stall detection. Define STORE_FWD_EN to add word store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  input  logic [WIDTH-1:0] st_addr,
  input  logic [WIDTH-1:0] st_data,
  input  logic [2:0]       st_mode,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [2:0]       ld_mode,
  output logic             ld_hazard,
  output logic             sb_empty,
  output logic             mem_WE,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
`ifdef STORE_FWD_EN
  output logic [2:0]       mem_modeAddr,
  output logic             ld_fwd_valid,
  output logic [WIDTH-1:0] ld_fwd_data
`else
  output logic [2:0]       mem_modeAddr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [2:0] size_of(input logic [2:0] mode);
    case (mode)
      3'b001:         size_of = 3'd4;
      3'b010, 3'b100: size_of = 3'd2;
      3'b011, 3'b101: size_of = 3'd1;
      default:        size_of = 3'd1;
    endcase
  endfunction

  logic [WIDTH-1:0] addr_r [DEPTH];
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [2:0]       mode_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             st_ready_r, sb_empty_r;
  logic [DEPTH-1:0] live_s, ov_s, inword_s;
  logic [17:0]      ld_lo_s, ld_hi_s;
  logic             trig_s, enq_s, drain_s, load_port_s, fwd_hit_s;

  assign ld_lo_s = {1'b0, ld_addr[16:0]};
  assign ld_hi_s = ld_lo_s + {15'd0, size_of(ld_mode)};
  assign trig_s  = (ld_addr == WIDTH'(32'h0000_0100));

  // Per-entry liveness, overlap with the load, and containment in the load's word.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [AW-1:0] age_s;
    logic [17:0]   lo_s, hi_s;
    assign age_s       = AW'(g) - rd_ptr_r;
    assign lo_s        = {1'b0, addr_r[g][16:0]};
    assign hi_s        = lo_s + {15'd0, size_of(mode_r[g])};
    assign live_s[g]   = ({1'b0, age_s} < count_r);
    assign ov_s[g]     = live_s[g] && (ld_lo_s < hi_s) && (lo_s < ld_hi_s);
    assign inword_s[g] = (lo_s >= ld_lo_s) && (hi_s <= ld_lo_s + 18'd4);
  end

`ifdef STORE_FWD_EN
  logic [AW-1:0] young_idx_s;
  logic          fwd_ok_s;

  // Youngest overlapping entry: scan oldest to youngest, last hit wins.
  always_comb begin
    young_idx_s = rd_ptr_r;
    for (int k = 0; k < DEPTH; k++) begin
      young_idx_s = ov_s[rd_ptr_r + AW'(k)] ? (rd_ptr_r + AW'(k)) : young_idx_s;
    end
  end

  assign fwd_ok_s = (ld_mode == 3'b001) && (mode_r[young_idx_s] == 3'b001) &&
                    (addr_r[young_idx_s][16:0] == ld_addr[16:0]) &&
                    ((ov_s & ~inword_s) == '0);
  assign fwd_hit_s    = ld_valid && !trig_s && (|ov_s) && fwd_ok_s;
  assign ld_fwd_valid = fwd_hit_s;

  // Byte-reversed word, matching what memory returns after a word store.
  always_comb begin
    ld_fwd_data = '0;
    if (fwd_hit_s) begin
      ld_fwd_data[31:0] = {data_r[young_idx_s][7:0],   data_r[young_idx_s][15:8],
                           data_r[young_idx_s][23:16], data_r[young_idx_s][31:24]};
    end else begin
      ld_fwd_data = '0;
    end
  end
`else
  assign fwd_hit_s = 1'b0;
`endif

  assign ld_hazard   = ld_valid && !trig_s && (|ov_s) && !fwd_hit_s;
  assign load_port_s = ld_valid && !ld_hazard && !fwd_hit_s;
  assign drain_s     = !load_port_s && (count_r != CW'(0));
  assign enq_s       = st_valid && st_ready_r;
  assign count_nxt_s = count_r + CW'(enq_s) - CW'(drain_s);
  assign st_ready    = st_ready_r;
  assign sb_empty    = sb_empty_r;

  // Memory port: head entry while draining, otherwise the load request.
  always_comb begin
    if (drain_s) begin
      mem_WE       = 1'b1;
      mem_A        = addr_r[rd_ptr_r];
      mem_WD       = data_r[rd_ptr_r];
      mem_modeAddr = mode_r[rd_ptr_r];
    end else begin
      mem_WE       = 1'b0;
      mem_A        = ld_addr;
      mem_WD       = '0;
      mem_modeAddr = ld_mode;
    end
  end

  // FIFO storage, pointers, occupancy and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
        mode_r[i] <= 3'b000;
      end
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      st_ready_r <= 1'b1;
      sb_empty_r <= 1'b1;
    end else begin
      if (enq_s) begin
        addr_r[wr_ptr_r] <= st_addr;
        data_r[wr_ptr_r] <= st_data;
        mode_r[wr_ptr_r] <= st_mode;
        wr_ptr_r         <= wr_ptr_r + AW'(1'b1);
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r    <= count_nxt_s;
      st_ready_r <= (count_nxt_s < CW'(DEPTH));
      sb_empty_r <= (count_nxt_s == CW'(0));
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, WIDTH=32); STORE_FWD_EN-aware.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_mode;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_mode;
  logic        ld_hazard, sb_empty, mem_WE;
  logic [31:0] mem_A, mem_WD;
  logic [2:0]  mem_modeAddr;
`ifdef STORE_FWD_EN
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mode(ld_mode), .ld_hazard(ld_hazard),
    .sb_empty(sb_empty),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
`ifdef STORE_FWD_EN
    .mem_modeAddr(mem_modeAddr),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data)
`else
    .mem_modeAddr(mem_modeAddr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] m);
    st_valid = v; st_addr = a; st_data = d; st_mode = m;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a, input logic [2:0] m);
    ld_valid = v; ld_addr = a; ld_mode = m;
  endtask

  initial begin
    rst_n = 1'b0;
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    set_ld(1'b0, 32'h0000_1234, 3'b011);
    cyc();
    @(negedge clk);
    check_eq("rst_st_ready", 32'(st_ready), 32'd1);
    check_eq("rst_sb_empty", 32'(sb_empty), 32'd1);
    check_eq("rst_ld_hazard", 32'(ld_hazard), 32'd0);
    check_eq("rst_mem_WE", 32'(mem_WE), 32'd0);
    check_eq("rst_mem_A", mem_A, 32'h0000_1234);
    check_eq("rst_mem_WD", mem_WD, 32'h0);
    check_eq("rst_mem_mode", 32'(mem_modeAddr), 32'd3);
    cyc();
    rst_n = 1'b1;

    // Single word store, drained the cycle after acceptance.
    set_st(1'b1, 32'h0001_0000, 32'h1122_3344, 3'b001);
    @(negedge clk);
    check_eq("t1_no_bypass", 32'(mem_WE), 32'd0);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    @(negedge clk);
    check_eq("t1_WE", 32'(mem_WE), 32'd1);
    check_eq("t1_A", mem_A, 32'h0001_0000);
    check_eq("t1_WD", mem_WD, 32'h1122_3344);
    check_eq("t1_mode", 32'(mem_modeAddr), 32'd1);
    check_eq("t1_not_empty", 32'(sb_empty), 32'd0);
    cyc();
    @(negedge clk);
    check_eq("t1_empty", 32'(sb_empty), 32'd1);
    check_eq("t1_idle_WE", 32'(mem_WE), 32'd0);
    cyc();

    // Fill while a non-overlapping load holds the port, then drain in order.
    set_ld(1'b1, 32'h0001_0100, 3'b001);
    for (int k = 0; k < 4; k++) begin
      set_st(1'b1, 32'h0001_0200 + 32'(4 * k), 32'hA0 + 32'(k), 3'b001);
      @(negedge clk);
      check_eq("t2_fill_ready", 32'(st_ready), 32'd1);
      check_eq("t2_fill_noWE", 32'(mem_WE), 32'd0);
      cyc();
    end
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    @(negedge clk);
    check_eq("t2_full_ready", 32'(st_ready), 32'd0);
    check_eq("t2_held_WE", 32'(mem_WE), 32'd0);
    check_eq("t2_held_A", mem_A, 32'h0001_0100);
    check_eq("t2_held_hz", 32'(ld_hazard), 32'd0);
    cyc();
    set_ld(1'b0, 32'h0001_0100, 3'b001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t2_drain_WE", 32'(mem_WE), 32'd1);
      check_eq("t2_drain_A", mem_A, 32'h0001_0200 + 32'(4 * k));
      check_eq("t2_drain_WD", mem_WD, 32'hA0 + 32'(k));
      check_eq("t2_drain_ready", 32'(st_ready), (k >= 1) ? 32'd1 : 32'd0);
      cyc();
    end
    @(negedge clk);
    check_eq("t2_empty", 32'(sb_empty), 32'd1);
    cyc();

    // Byte store @0x10003 against several loads.
    set_st(1'b1, 32'h0001_0003, 32'h55, 3'b011);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    set_ld(1'b1, 32'h0001_0004, 3'b001);
    @(negedge clk);
    check_eq("t3_w4_hz", 32'(ld_hazard), 32'd0);
    check_eq("t3_w4_WE", 32'(mem_WE), 32'd0);
    check_eq("t3_w4_A", mem_A, 32'h0001_0004);
    cyc();
    set_ld(1'b1, 32'h0001_0002, 3'b011);
    @(negedge clk);
    check_eq("t3_b2_hz", 32'(ld_hazard), 32'd0);
    cyc();
    set_ld(1'b1, 32'h0001_0000, 3'b001);
    @(negedge clk);
    check_eq("t3_w0_hz", 32'(ld_hazard), 32'd1);
    check_eq("t3_w0_WE", 32'(mem_WE), 32'd1);
    check_eq("t3_w0_A", mem_A, 32'h0001_0003);
    check_eq("t3_w0_mode", 32'(mem_modeAddr), 32'd3);
    cyc();
    @(negedge clk);
    check_eq("t3_after_hz", 32'(ld_hazard), 32'd0);
    check_eq("t3_after_A", mem_A, 32'h0001_0000);
    check_eq("t3_after_WE", 32'(mem_WE), 32'd0);
    check_eq("t3_after_empty", 32'(sb_empty), 32'd1);
    cyc();

    // Trigger register 0x100 never hazards.
    set_ld(1'b0, 32'h0, 3'b001);
    set_st(1'b1, 32'h0000_0100, 32'h77, 3'b001);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    set_ld(1'b1, 32'h0000_0100, 3'b001);
    @(negedge clk);
    check_eq("t4_hz", 32'(ld_hazard), 32'd0);
    check_eq("t4_WE", 32'(mem_WE), 32'd0);
    check_eq("t4_A", mem_A, 32'h0000_0100);
    cyc();
    set_ld(1'b0, 32'h0, 3'b001);
    @(negedge clk);
    check_eq("t4_drain_A", mem_A, 32'h0000_0100);
    check_eq("t4_drain_WD", mem_WD, 32'h77);
    cyc();

    // Full buffer with a simultaneous store and drain, then reset mid-operation.
    set_ld(1'b1, 32'h0001_0100, 3'b001);
    for (int k = 0; k < 4; k++) begin
      set_st(1'b1, 32'h0001_0200 + 32'(4 * k), 32'hB0 + 32'(k), 3'b001);
      cyc();
    end
    set_ld(1'b0, 32'h0001_0100, 3'b001);
    set_st(1'b1, 32'h0001_0300, 32'hEE, 3'b001);
    @(negedge clk);
    check_eq("t5_full_ready", 32'(st_ready), 32'd0);
    check_eq("t5_full_WE", 32'(mem_WE), 32'd1);
    check_eq("t5_full_A", mem_A, 32'h0001_0200);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    set_ld(1'b1, 32'h0001_0100, 3'b001);
    @(negedge clk);
    check_eq("t5_ready_rise", 32'(st_ready), 32'd1);
    cyc();
    set_st(1'b1, 32'h0001_0400, 32'hCC, 3'b001);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    @(negedge clk);
    check_eq("t5_count3_then_full", 32'(st_ready), 32'd0);
    cyc();
    set_ld(1'b0, 32'h0001_0100, 3'b001);
    @(negedge clk);
    check_eq("t5_order_A", mem_A, 32'h0001_0204);
    check_eq("t5_order_WD", mem_WD, 32'hB1);
    cyc();
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_WE", 32'(mem_WE), 32'd0);
    check_eq("t5_rst_empty", 32'(sb_empty), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("t5_no_write", 32'(mem_WE), 32'd0);
      cyc();
    end

    // Word store then same-address word load; then a half-word load.
    set_st(1'b1, 32'h0001_0020, 32'hAABB_CCDD, 3'b001);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    set_ld(1'b1, 32'h0001_0020, 3'b001);
    @(negedge clk);
`ifdef STORE_FWD_EN
    check_eq("t6_fwd_valid", 32'(ld_fwd_valid), 32'd1);
    check_eq("t6_fwd_data", ld_fwd_data, 32'hDDCC_BBAA);
    check_eq("t6_fwd_hz", 32'(ld_hazard), 32'd0);
`else
    check_eq("t6_word_hz", 32'(ld_hazard), 32'd1);
`endif
    check_eq("t6_drain_WE", 32'(mem_WE), 32'd1);
    check_eq("t6_drain_A", mem_A, 32'h0001_0020);
    cyc();
    set_ld(1'b0, 32'h0, 3'b001);
    set_st(1'b1, 32'h0001_0020, 32'hAABB_CCDD, 3'b001);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b001);
    set_ld(1'b1, 32'h0001_0020, 3'b010);
    @(negedge clk);
    check_eq("t6_half_hz", 32'(ld_hazard), 32'd1);
`ifdef STORE_FWD_EN
    check_eq("t6_half_nofwd", 32'(ld_fwd_valid), 32'd0);
`endif
    cyc();
    set_ld(1'b0, 32'h0, 3'b001);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
